// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot loader / fetch controller owning the 64-word instruction memory ports.
//   Loader side : load_start_i, load_count_i, load_valid_i, load_data_i -> load_ready_o
//   Core side   : core_fetch_req_i, core_fetch_addr_i -> core_instr_o, core_instr_valid_o, core_stall_o
//   Memory side : mem_we_o, mem_waddr_o, mem_wdata_o, mem_raddr_o -> mem_rdata_i (combinational read)
//   Status      : load_done_o (program resident, core running), fetch_err_o (sticky misaligned fetch)
//   Option      : define IMEM_AUTOBOOT_EN to leave reset straight into RUN on the preloaded image.
module imem_load_ctrl #(
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start_i,
  input  logic [6:0]    load_count_i,
  input  logic          load_valid_i,
  input  logic [31:0]   load_data_i,
  output logic          load_ready_o,
  input  logic          core_fetch_req_i,
  input  logic [31:0]   core_fetch_addr_i,
  output logic [31:0]   core_instr_o,
  output logic          core_instr_valid_o,
  output logic          core_stall_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [AW-1:0] mem_raddr_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          load_done_o,
  output logic          fetch_err_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
`ifdef IMEM_AUTOBOOT_EN
  localparam state_e RST_STATE = RUN;
`else
  localparam state_e RST_STATE = IDLE;
`endif
  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d, tgt_q, tgt_d, clamp;
  logic          we_q, we_d, valid_q, valid_d, err_q, err_d, misaligned;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d, instr_q, instr_d;
  logic          unused_addr;
  assign unused_addr        = ^core_fetch_addr_i[31:AW+2];
  assign clamp              = (32'(load_count_i) > DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(load_count_i);
  assign misaligned         = core_fetch_addr_i[1:0] != 2'b00;
  assign mem_raddr_o        = core_fetch_addr_i[AW+1:2];
  assign load_ready_o       = state_q == LOAD;
  assign core_stall_o       = state_q != RUN;
  assign load_done_o        = state_q == RUN;
  assign mem_we_o           = we_q;
  assign mem_waddr_o        = waddr_q;
  assign mem_wdata_o        = wdata_q;
  assign core_instr_o       = instr_q;
  assign core_instr_valid_o = valid_q;
  assign fetch_err_o        = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (load_start_i) begin
        tgt_d   = clamp;
        cnt_d   = '0;
        state_d = (clamp == '0) ? RUN : LOAD;
      end
      LOAD: if (load_valid_i) begin
        we_d    = 1'b1;
        waddr_d = cnt_q[AW-1:0];
        wdata_d = load_data_i;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == tgt_q - 1'b1) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: if (load_start_i) begin
        // a fetch issued alongside load_start is dropped
        tgt_d   = clamp;
        cnt_d   = '0;
        state_d = (clamp == '0) ? RUN : LOAD;
      end else if (core_fetch_req_i) begin
        valid_d = 1'b1;
        instr_d = misaligned ? NOP_INSTR : mem_rdata_i;
        err_d   = err_q | misaligned;
      end
      default: state_d = RST_STATE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: scoreboard bench for imem_load_ctrl with a behavioural memory and reference image.
module tb_imem_load_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        load_start = 1'b0, load_valid = 1'b0, load_ready;
  logic [6:0]  load_count = '0;
  logic [31:0] load_data = '0;
  logic        core_fetch_req = 1'b0;
  logic [31:0] core_fetch_addr = '0, core_instr;
  logic        core_instr_valid, core_stall, mem_we, load_done, fetch_err;
  logic [5:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [37:0] wq [$];
  logic [31:0] fq [$];
  logic [31:0] last_instr = '0;
  logic [31:0] prog [3];
  logic        exp_err = 1'b0;
  int          tests = 0, fails = 0, wr_cnt = 0;

  imem_load_ctrl dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start), .load_count_i(load_count), .load_valid_i(load_valid),
    .load_data_i(load_data), .load_ready_o(load_ready),
    .core_fetch_req_i(core_fetch_req), .core_fetch_addr_i(core_fetch_addr),
    .core_instr_o(core_instr), .core_instr_valid_o(core_instr_valid), .core_stall_o(core_stall),
    .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
    .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .load_done_o(load_done), .fetch_err_o(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
  end
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (mem_we) begin
      wr_cnt++;
      if (wq.size() == 0) chk("unexpected_write", {26'b0, mem_waddr}, 32'hFFFF_FFFF);
      else begin
        logic [37:0] e;
        e = wq.pop_front();
        chk("write_addr", {26'b0, mem_waddr}, {26'b0, e[37:32]});
        chk("write_data", mem_wdata, e[31:0]);
        ref_mem[e[37:32]] = e[31:0];
      end
    end
    if (core_instr_valid) begin
      if (fq.size() == 0) chk("unexpected_fetch", core_instr, 32'hDEAD_BEEF);
      else begin
        last_instr = fq.pop_front();
        chk("fetch_instr", core_instr, last_instr);
      end
    end else chk("instr_hold", core_instr, last_instr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    core_fetch_req = 1'b1;
    core_fetch_addr = a;
    if (a[1:0] != 2'b00) begin
      fq.push_back(32'h0000_0013);
      exp_err = 1'b1;
    end else fq.push_back(ref_mem[a[7:2]]);
    tick();
    core_fetch_req = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_ready", {31'b0, load_ready}, 0);
    chk("rst_instr", core_instr, 0);
    chk("rst_valid", {31'b0, core_instr_valid}, 0);
    chk("rst_stall", {31'b0, core_stall}, 1);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_waddr", {26'b0, mem_waddr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", {31'b0, load_done}, 0);
    chk("rst_err", {31'b0, fetch_err}, 0);
  endtask

  task automatic do_load(input int cnt, input bit gaps, input bit fetch_too, input int stop_after, input bit fixed);
    int tgt;
    tgt = cnt > 64 ? 64 : cnt;
    load_start = 1'b1;
    load_count = cnt[6:0];
    if (fetch_too) begin
      core_fetch_req = 1'b1;
      core_fetch_addr = $urandom & 32'hFFFF_FFFC;
    end
    tick();
    load_start = 1'b0;
    core_fetch_req = 1'b0;
    if (tgt == 0) begin
      chk("zero_done", {31'b0, load_done}, 1);
      chk("zero_stall", {31'b0, core_stall}, 0);
      return;
    end
    chk("load_stall", {31'b0, core_stall}, 1);
    chk("load_not_done", {31'b0, load_done}, 0);
    for (int k = 0; k < tgt && k < stop_after; k++) begin
      if (gaps) begin
        load_valid = 1'b0;
        tick();
        tick();
      end
      load_valid = 1'b1;
      load_data = fixed ? prog[k] : $urandom;
      if (k == 0 || gaps) chk("load_ready", {31'b0, load_ready}, 1);
      wq.push_back({k[5:0], load_data});
      tick();
    end
    load_valid = 1'b0;
    if (stop_after >= tgt) begin
      chk("done_after_last", {31'b0, load_done}, 1);
      chk("run_stall", {31'b0, core_stall}, 0);
      chk("ready_drop", {31'b0, load_ready}, 0);
    end
  endtask

  initial begin
    int w0;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    tick();
    tick();
    chk_reset();
    rst = 1'b0;
    tick();
    chk("idle_stall", {31'b0, core_stall}, 1);
    core_fetch_req = 1'b1;
    core_fetch_addr = 32'h4;
    tick();
    core_fetch_req = 1'b0;
    do_load(3, 0, 0, 99, 1);
    tick();
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'h0);
    tick();
    fetch(32'h6);
    tick();
    chk("err_set", {31'b0, fetch_err}, 1);
    fetch(32'h4);
    tick();
    chk("err_sticky", {31'b0, fetch_err}, 1);
    do_load(5, 1, 1, 99, 0);
    tick();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      fetch(a);
      if ($urandom_range(2) == 0) tick();
    end
    tick();
    chk("err_rand", {31'b0, fetch_err}, {31'b0, exp_err});
    w0 = wr_cnt;
    do_load(0, 0, 0, 99, 0);
    tick();
    chk("zero_writes", wr_cnt - w0, 0);
    w0 = wr_cnt;
    do_load(100, 0, 0, 99, 0);
    tick();
    chk("clamp_writes", wr_cnt - w0, 64);
    for (int i = 0; i < 16; i++) fetch($urandom_range(255) << 2);
    tick();
    do_load(5, 0, 0, 2, 0);
    tick();
    rst = 1'b1;
    wq.delete();
    fq.delete();
    last_instr = '0;
    exp_err = 1'b0;
    #1;
    chk_reset();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_stall", {31'b0, core_stall}, 1);
    w0 = wr_cnt;
    do_load(3, 0, 0, 99, 1);
    tick();
    chk("reload_writes", wr_cnt - w0, 3);
    fetch(32'h104);
    fetch(32'h8);
    tick();
    chk("wrap_err", {31'b0, fetch_err}, 0);
    tick();
    chk("wq_empty", wq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
